// File: rtl/mainmenu_ctrl.sv
// mainmenu_ctrl: main-menu navigation and game-start handshake.
// Five debounced buttons move a highlight over a 2-column option grid.
// Enter latches the highlighted option and requests a game start.
// The menu returns when the game core pulses game_over.
// Optional feature: define MAINMENU_AUTOREPEAT_EN to auto-repeat a held nav button.
module mainmenu_ctrl #(
  parameter logic [23:0] REPEAT_DELAY = 24'd12500000,
  parameter logic [23:0] REPEAT_RATE  = 24'd2500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_enter,
  input  logic        start_ack,
  input  logic        game_over,
  output logic [2:0]  sel,
  output logic [28:0] metadata,
  output logic        start_req,
  output logic [2:0]  game_mode,
  output logic        menu_active
);

  localparam logic [1:0] MENU = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  logic [1:0] state;
  logic [4:0] btnRaw;
  logic [4:0] sync1;
  logic [4:0] sync2;
  logic [4:0] prevSync;
  logic [4:0] press;
  logic [3:0] navReq;
  logic [2:0] navSel;

  // Bit order: [0]=up [1]=down [2]=left [3]=right [4]=enter
  assign btnRaw = {btn_enter, btn_right, btn_left, btn_down, btn_up};

  // Two-flop synchronizers plus edge-detect register, running in every state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      prevSync <= '0;
    end else begin
      sync1    <= btnRaw;
      sync2    <= sync1;
      prevSync <= sync2;
    end
  end

  assign press = sync2 & ~prevSync;

`ifdef MAINMENU_AUTOREPEAT_EN
  logic [23:0] repCnt;
  logic        repPhase;
  logic        oneHeld;
  logic        repFire;

  assign oneHeld = (state == MENU) && $onehot(sync2[3:0]);
  // repCnt equals cycles since the press move; after the first repeat it restarts at 1
  assign repFire = oneHeld &&
                   (repPhase ? (repCnt == REPEAT_RATE) : (repCnt == REPEAT_DELAY));

  // Hold-time counter for the single held nav button
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      repCnt   <= '0;
      repPhase <= 1'b0;
    end else if (!oneHeld) begin
      repCnt   <= '0;
      repPhase <= 1'b0;
    end else if (repFire) begin
      repCnt   <= 24'd1;
      repPhase <= 1'b1;
    end else begin
      repCnt   <= repCnt + 24'd1;
    end
  end

  assign navReq = press[3:0] | (repFire ? sync2[3:0] : 4'b0000);
`else
  logic unusedParams;
  assign unusedParams = ^{REPEAT_DELAY, REPEAT_RATE};
  assign navReq = press[3:0];
`endif

  // Next highlight from the highest-priority nav request (up > down > left > right)
  always_comb begin
    navSel = sel;
    if (navReq[0]) begin
      case (sel)
        3'd1:    navSel = 3'd0;
        3'd2:    navSel = 3'd1;
        3'd4:    navSel = 3'd3;
        default: navSel = sel;
      endcase
    end else if (navReq[1]) begin
      case (sel)
        3'd0:    navSel = 3'd1;
        3'd1:    navSel = 3'd2;
        3'd3:    navSel = 3'd4;
        default: navSel = sel;
      endcase
    end else if (navReq[2]) begin
      case (sel)
        3'd3:    navSel = 3'd0;
        3'd4:    navSel = 3'd1;
        default: navSel = sel;
      endcase
    end else if (navReq[3]) begin
      case (sel)
        3'd0:    navSel = 3'd3;
        3'd1:    navSel = 3'd4;
        3'd2:    navSel = 3'd4;
        default: navSel = sel;
      endcase
    end
  end

  // Menu / start-request / running FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= MENU;
      sel       <= '0;
      game_mode <= '0;
      start_req <= 1'b0;
    end else begin
      case (state)
        MENU: begin
          if (press[4]) begin
            game_mode <= sel;
            start_req <= 1'b1;
            state     <= REQ;
          end else begin
            sel <= navSel;
          end
        end
        REQ: begin
          if (start_ack) begin
            start_req <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (game_over) state <= MENU;
        end
        default: state <= MENU;
      endcase
    end
  end

  assign menu_active = (state == MENU);
  assign metadata    = {sel, 26'd0};

endmodule

// File: tb/tb_mainmenu_ctrl.sv
// tb_mainmenu_ctrl: directed scenarios plus randomized stimulus checked
// every cycle against a behavioural menu model.
module tb_mainmenu_ctrl;

  localparam int RD = 10;
  localparam int RR = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  btns;
  logic        start_ack;
  logic        game_over;
  logic        btn_up, btn_down, btn_left, btn_right, btn_enter;
  logic [2:0]  sel;
  logic [28:0] metadata;
  logic        start_req;
  logic [2:0]  game_mode;
  logic        menu_active;

  assign btn_up    = btns[0];
  assign btn_down  = btns[1];
  assign btn_left  = btns[2];
  assign btn_right = btns[3];
  assign btn_enter = btns[4];

  mainmenu_ctrl #(
    .REPEAT_DELAY(24'd10),
    .REPEAT_RATE (24'd4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_enter  (btn_enter),
    .start_ack  (start_ack),
    .game_over  (game_over),
    .sel        (sel),
    .metadata   (metadata),
    .start_req  (start_req),
    .game_mode  (game_mode),
    .menu_active(menu_active)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: grid as move tables, buttons as a delay line
  logic [2:0] upT    [0:4] = '{3'd0, 3'd0, 3'd1, 3'd3, 3'd3};
  logic [2:0] downT  [0:4] = '{3'd1, 3'd2, 3'd2, 3'd4, 3'd4};
  logic [2:0] leftT  [0:4] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1};
  logic [2:0] rightT [0:4] = '{3'd3, 3'd4, 3'd4, 3'd3, 3'd4};

  logic [4:0] hist [0:3];
  int         run;
  int         mState;   // 0 menu, 1 waiting for ack, 2 game running
  logic [2:0] mSel;
  logic [2:0] mMode;
  logic       mReq;

  task automatic modelReset();
    for (int i = 0; i < 4; i++) hist[i] = '0;
    run = 0; mState = 0; mSel = 0; mMode = 0; mReq = 0;
  endtask

  task automatic modelStep(input logic [4:0] b, input logic ack, input logic go);
    logic [4:0] lvl, pr;
    logic [3:0] nav;
    int e;
    hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = b;
    // a raw input sampled two edges ago is the level acted on at this edge
    lvl = hist[2];
    pr  = hist[2] & ~hist[3];
    nav = pr[3:0];
`ifdef MAINMENU_AUTOREPEAT_EN
    if (mState == 0 && $countones(lvl[3:0]) == 1) run++;
    else run = 0;
    if (run > 0) begin
      e = run - 1;
      if (e == RD || (e > RD && (e - RD) % RR == 0)) nav = nav | lvl[3:0];
    end
`else
    e = 0;
`endif
    case (mState)
      0: begin
        if (pr[4]) begin
          mMode = mSel; mReq = 1'b1; mState = 1;
        end else if (nav[0]) mSel = upT[mSel];
        else if (nav[1]) mSel = downT[mSel];
        else if (nav[2]) mSel = leftT[mSel];
        else if (nav[3]) mSel = rightT[mSel];
      end
      1: if (ack) begin mReq = 1'b0; mState = 2; end
      default: if (go) mState = 0;
    endcase
  endtask

  task automatic compareAll();
    checkVal("sel", 32'(sel), 32'(mSel));
    checkVal("metadata", 32'(metadata), 32'({mSel, 26'd0}));
    checkVal("start_req", 32'(start_req), 32'(mReq));
    checkVal("game_mode", 32'(game_mode), 32'(mMode));
    checkVal("menu_active", 32'(menu_active), 32'(mState == 0));
  endtask

  // Drive while clock is low, step model at the edge, compare 1ns later
  task automatic cycle(input logic [4:0] b, input logic ack, input logic go);
    btns = b; start_ack = ack; game_over = go;
    @(posedge clock);
    modelStep(b, ack, go);
    #1 compareAll();
    @(negedge clock);
  endtask

  task automatic doReset();
    reset = 1'b1;
    modelReset();
    #1 compareAll();
    @(posedge clock);
    #1 compareAll();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic pulse(input logic [4:0] b);
    repeat (4) cycle(b, 1'b0, 1'b0);
    repeat (4) cycle(5'b0, 1'b0, 1'b0);
  endtask

  localparam logic [4:0] UP = 5'b00001, DN = 5'b00010, LT = 5'b00100,
                         RT = 5'b01000, EN = 5'b10000;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    btns = '0; start_ack = 0; game_over = 0; reset = 1'b1;
    modelReset();
    #1 compareAll();
    checkVal("reset_menu_active", 32'(menu_active), 32'd1);
    @(negedge clock);
    reset = 1'b0;

    // down twice, then saturate at the bottom of the left column
    pulse(DN);
    checkVal("down1", 32'(sel), 32'd1);
    pulse(DN);
    checkVal("down2", 32'(sel), 32'd2);
    checkVal("meta_sel", 32'(metadata[28:26]), 32'd2);
    pulse(DN);
    checkVal("down_sat", 32'(sel), 32'd2);

    // column moves from sel=1
    pulse(UP);
    checkVal("up_to1", 32'(sel), 32'd1);
    pulse(RT);
    checkVal("right_1_4", 32'(sel), 32'd4);
    pulse(UP);
    checkVal("up_4_3", 32'(sel), 32'd3);
    pulse(LT);
    checkVal("left_3_0", 32'(sel), 32'd0);
    pulse(UP);
    checkVal("up_sat0", 32'(sel), 32'd0);

    // enter beats up in the same cycle
    pulse(DN); pulse(DN);
    pulse(EN | UP);
    checkVal("mode_latch", 32'(game_mode), 32'd2);
    checkVal("req_set", 32'(start_req), 32'd1);
    checkVal("sel_kept", 32'(sel), 32'd2);
    pulse(UP); pulse(UP);
    checkVal("req_ignores_up", 32'(sel), 32'd2);

    // ack, then game_over, with enter held throughout
    cycle(EN, 1'b1, 1'b0);
    checkVal("ack_clears_req", 32'(start_req), 32'd0);
    checkVal("run_inactive", 32'(menu_active), 32'd0);
    repeat (5) cycle(EN, 1'b0, 1'b0);
    cycle(EN, 1'b0, 1'b1);
    checkVal("back_menu", 32'(menu_active), 32'd1);
    checkVal("back_sel", 32'(sel), 32'd2);
    repeat (6) cycle(EN, 1'b0, 1'b0);
    checkVal("held_enter_no_req", 32'(start_req), 32'd0);
    cycle(5'b0, 1'b0, 1'b0);

    // async reset while start_req is high
    pulse(EN);
    checkVal("req_before_reset", 32'(start_req), 32'd1);
    #2 reset = 1'b1;
    modelReset();
    #1;
    checkVal("async_req", 32'(start_req), 32'd0);
    checkVal("async_sel", 32'(sel), 32'd0);
    checkVal("async_menu", 32'(menu_active), 32'd1);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // held down from sel=0: press move at edge 3, repeat at edge 13
    for (int i = 1; i <= 20; i++) begin
      cycle(DN, 1'b0, 1'b0);
      if (i == 3) checkVal("hold_edge3", 32'(sel), 32'd1);
      if (i == 12) checkVal("hold_edge12", 32'(sel), 32'd1);
`ifdef MAINMENU_AUTOREPEAT_EN
      if (i == 13) checkVal("hold_edge13", 32'(sel), 32'd2);
`else
      if (i == 13) checkVal("hold_edge13", 32'(sel), 32'd1);
`endif
    end
    repeat (4) cycle(5'b0, 1'b0, 1'b0);

    // randomized traffic with long holds so auto-repeat gets exercised
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] b;
      b = btns;
      if ($urandom_range(0, 7) == 0) b = 5'($urandom & $urandom);
      if ($urandom_range(0, 599) == 0) doReset();
      else cycle(b, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
